// File: rtl/matrix_conv2d_stream.sv
// Streaming valid-mode 2-D convolution: loads an MxM image and FxF kernel, then
// produces one full-precision window sum per F*F+1 cycles over a valid/ready port.
module matrix_conv2d_stream #(
  parameter int M    = 4,
  parameter int F    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW + $clog2(F*F)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [3:0]      stride,
  input  logic            signed_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out,
  output logic            out_last,
  output logic            busy,
  output logic            err
);

  localparam int XAW = $clog2(M*M);
  localparam int HAW = (F == 1) ? 1 : $clog2(F*F);
  localparam int PW  = (ACCW > 2*DW+2) ? ACCW : 2*DW+2;

  typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

  state_t r_state, w_next;

  logic [DW-1:0]          r_x [0:(1<<XAW)-1];
  logic [DW-1:0]          r_h [0:(1<<HAW)-1];
  logic [XAW-1:0]         r_idx;
  logic [3:0]             r_stride;
  logic                   r_signed;
  logic                   r_err;
  logic [3:0]             r_row, r_col, r_ki, r_kj;
  logic [HAW-1:0]         r_kk;
  logic signed [ACCW-1:0] r_acc;

  logic                   w_beat, w_load_done, w_mac_done, w_emit_hs;
  logic                   w_col_wrap, w_row_wrap, w_last;
  logic [XAW-1:0]         w_xaddr;
  logic signed [ACCW-1:0] w_prod;

  // Operands widened by one bit so one signed multiplier covers both modes;
  // modular truncation to ACCW is exact because the true sum always fits.
  function automatic logic signed [ACCW-1:0] mac_product(
    input logic [DW-1:0] x,
    input logic [DW-1:0] h,
    input logic          sm
  );
    logic signed [DW:0]   ex, eh;
    logic signed [PW-1:0] p;
    ex = {sm & x[DW-1], x};
    eh = {sm & h[DW-1], h};
    p  = PW'(ex) * PW'(eh);
    return p[ACCW-1:0];
  endfunction

  assign w_beat      = in_valid && (r_state == LOAD);
  assign w_load_done = w_beat && (r_idx == XAW'(M*M-1));
  assign w_mac_done  = (r_state == MAC) && (r_kk == HAW'(F*F-1));
  assign w_emit_hs   = (r_state == EMIT) && out_ready;
  assign w_col_wrap  = (int'(r_col) + int'(r_stride) + F) > M;
  assign w_row_wrap  = (int'(r_row) + int'(r_stride) + F) > M;
  assign w_last      = w_col_wrap && w_row_wrap;
  assign w_xaddr     = XAW'((int'(r_row) + int'(r_ki)) * M + int'(r_col) + int'(r_kj));
  assign w_prod      = mac_product(r_x[w_xaddr], r_h[r_kk], r_signed);

  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == EMIT);
  assign out_last  = (r_state == EMIT) && w_last;
  assign out       = r_acc;
  assign busy      = (r_state != LOAD) || (r_idx != '0);
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_load_done) w_next = MAC;
      MAC:     if (w_mac_done)  w_next = EMIT;
      EMIT:    if (out_ready)   w_next = w_last ? LOAD : MAC;
      default: w_next = LOAD;
    endcase
  end

  // Load stage: image and kernel storage, rewritten only by the next frame.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_x[r_idx] <= a;
      if (int'(r_idx) < F*F) r_h[HAW'(r_idx)] <= b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_stride <= 4'd1;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_ki     <= '0;
      r_kj     <= '0;
      r_kk     <= '0;
      r_acc    <= '0;
    end else begin
      r_err <= w_beat && (r_idx == '0) && (stride == 4'd0);
      if (w_beat) begin
        r_idx <= w_load_done ? '0 : r_idx + 1'b1;
        if (r_idx == '0) begin
          r_stride <= (stride == 4'd0) ? 4'd1 : stride;
          r_signed <= signed_mode;
        end
      end
      if (w_load_done) begin
        r_row <= '0;
        r_col <= '0;
        r_ki  <= '0;
        r_kj  <= '0;
        r_kk  <= '0;
      end
      // MAC stage: one product per cycle, accumulator restarts on the first one.
      if (r_state == MAC) begin
        r_acc <= (r_kk == '0) ? w_prod : r_acc + w_prod;
        if (w_mac_done) begin
          r_kk <= '0;
          r_ki <= '0;
          r_kj <= '0;
        end else begin
          r_kk <= r_kk + 1'b1;
          if (r_kj == 4'(F-1)) begin
            r_kj <= '0;
            r_ki <= r_ki + 1'b1;
          end else begin
            r_kj <= r_kj + 1'b1;
          end
        end
      end
      // Emit stage: advance the raster origin once the result is taken.
      if (w_emit_hs && !w_last) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + r_stride;
        end else begin
          r_col <= r_col + r_stride;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_conv2d_stream.sv
// Scoreboard bench for matrix_conv2d_stream with M=3, F=2, DW=8.
module tb_matrix_conv2d_stream;

  localparam int M    = 3;
  localparam int F    = 2;
  localparam int DW   = 8;
  localparam int ACCW = 2*DW + $clog2(F*F);

  typedef struct {
    logic [ACCW-1:0] v;
    logic            last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic [3:0]      stride;
  logic            signed_mode;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out;
  logic            out_last;
  logic            busy;
  logic            err;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int err_cnt = 0;
  exp_t exp_q[$];
  logic [DW-1:0] tx [M*M];
  logic [DW-1:0] th [F*F];

  matrix_conv2d_stream #(.M(M), .F(F), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .stride(stride), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  function automatic void push(input longint v, input bit l);
    exp_t e;
    e.v = v[ACCW-1:0];
    e.last = l;
    exp_q.push_back(e);
  endfunction

  // Reference: plain nested-loop valid convolution over the bench arrays.
  function automatic int model_push(input int s, input bit sm);
    int se, o;
    longint acc, xv, hv;
    se = (s == 0) ? 1 : s;
    o = (M - F) / se + 1;
    for (int r = 0; r < o; r++)
      for (int c = 0; c < o; c++) begin
        acc = 0;
        for (int i = 0; i < F; i++)
          for (int j = 0; j < F; j++) begin
            xv = sm ? longint'($signed(tx[(r*se+i)*M + c*se + j])) : longint'(tx[(r*se+i)*M + c*se + j]);
            hv = sm ? longint'($signed(th[i*F+j])) : longint'(th[i*F+j]);
            acc += xv * hv;
          end
        push(acc, (r == o-1) && (c == o-1));
      end
    return o*o;
  endfunction

  task automatic load_frame(input logic [3:0] s, input bit sm);
    int n;
    for (int k = 0; k < M*M; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL load_in_ready beat %0d got %b want 1", k, in_ready);
      end
      if (k == 0) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got %b want 0", busy); end
      end
      if (k == 1) begin
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b want 1", busy); end
        if (err !== (s == 4'd0)) begin errors++; $display("FAIL err_pulse got %b want %b", err, (s == 4'd0)); end
      end
      in_valid    = 1'b1;
      a           = tx[k];
      b           = (k < F*F) ? th[k] : DW'($urandom);
      stride      = (k == 0) ? s : 4'($urandom);
      signed_mode = (k == 0) ? sm : 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = DW'($urandom);
    b = DW'($urandom);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mac_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mac_in_ready got %b want 0", in_ready); end
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != F*F) begin errors++; $display("FAIL first_latency got %0d want %0d", n, F*F); end
  endtask

  task automatic collect(input int nres, input int stall_at, input int stall_len);
    int got, budget;
    logic [ACCW-1:0] hold;
    logic hold_l;
    exp_t e;
    got = 0;
    budget = 200;
    out_ready = 1'b1;
    while (got < nres && budget > 0) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL emit_in_ready got %b want 0", in_ready); end
        if (got == stall_at) begin
          out_ready = 1'b0;
          hold = out;
          hold_l = out_last;
          repeat (stall_len) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", out_valid); end
            if (out !== hold || out_last !== hold_l) begin
              errors++; $display("FAIL stall_hold got %0d/%b want %0d/%b", out, out_last, hold, hold_l);
            end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
          end
          out_ready = 1'b1;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_result got %0d want none", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e.v || out_last !== e.last) begin
            errors++; $display("FAIL result %0d got %0d last %b want %0d last %b", got, out, out_last, e.v, e.last);
          end
        end
        got++;
      end
      @(negedge clk);
      budget--;
    end
    checks++;
    if (got != nres) begin errors++; $display("FAIL result_timeout got %0d want %0d", got, nres); end
  endtask

  task automatic check_frame_end(input int hs_before, input int nres);
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL end_in_ready got %b want 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL end_busy got %b want 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL end_out_valid got %b want 0", out_valid); end
    if (hs_cnt - hs_before != nres) begin
      errors++; $display("FAIL handshakes got %0d want %0d", hs_cnt - hs_before, nres);
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
  endtask

  task automatic set_seq_data();
    for (int k = 0; k < M*M; k++) tx[k] = DW'(k + 1);
    for (int k = 0; k < F*F; k++) th[k] = DW'(k + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; stride = 4'd1; signed_mode = 1'b0; out_ready = 1'b1;
    #3;
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out !== '0) begin errors++; $display("FAIL rst_out got %0d want 0", out); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int hs0;
    set_seq_data();
    push(37, 0); push(47, 0); push(67, 0); push(77, 1);
    hs0 = hs_cnt;
    load_frame(4'd1, 1'b0);
    collect(4, -1, 0);
    check_frame_end(hs0, 4);
  endtask

  task automatic test_stride2();
    int hs0;
    set_seq_data();
    push(37, 1);
    hs0 = hs_cnt;
    load_frame(4'd2, 1'b0);
    collect(1, -1, 0);
    check_frame_end(hs0, 1);
  endtask

  task automatic test_sign_modes();
    int hs0;
    for (int k = 0; k < M*M; k++) tx[k] = 8'hFF;
    for (int k = 0; k < F*F; k++) th[k] = 8'h80;
    repeat (4) push(512, 0);
    exp_q[3].last = 1'b1;
    hs0 = hs_cnt;
    load_frame(4'd1, 1'b1);
    collect(4, -1, 0);
    check_frame_end(hs0, 4);
    repeat (4) push(130560, 0);
    exp_q[3].last = 1'b1;
    hs0 = hs_cnt;
    load_frame(4'd1, 1'b0);
    collect(4, -1, 0);
    check_frame_end(hs0, 4);
  endtask

  task automatic test_stride0();
    int hs0, e0;
    set_seq_data();
    push(37, 0); push(47, 0); push(67, 0); push(77, 1);
    hs0 = hs_cnt;
    e0 = err_cnt;
    load_frame(4'd0, 1'b0);
    collect(4, -1, 0);
    check_frame_end(hs0, 4);
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL err_count got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_backpressure();
    int hs0;
    set_seq_data();
    push(37, 0); push(47, 0); push(67, 0); push(77, 1);
    hs0 = hs_cnt;
    load_frame(4'd1, 1'b0);
    collect(4, 1, 5);
    check_frame_end(hs0, 4);
  endtask

  task automatic test_back_to_back();
    int hs0, n, s;
    bit sm;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < M*M; k++) tx[k] = DW'($urandom);
      for (int k = 0; k < F*F; k++) th[k] = DW'($urandom);
      sm = (f % 2) == 0;
      s = (f < 2) ? 1 : $urandom_range(1, 3);
      n = model_push(s, sm);
      hs0 = hs_cnt;
      load_frame(4'(s), sm);
      collect(n, -1, 0);
      check_frame_end(hs0, n);
    end
  endtask

  task automatic test_reset_mid();
    int hs0;
    set_seq_data();
    push(37, 0);
    load_frame(4'd1, 1'b0);
    collect(1, -1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    if (out !== '0) begin errors++; $display("FAIL mid_rst_out got %0d want 0", out); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL mid_rst_out_last got %b want 0", out_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", err); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < M*M; k++) tx[k] = DW'(k + 1);
    th[0] = 8'd0; th[1] = 8'd0; th[2] = 8'd0; th[3] = 8'd1;
    push(5, 0); push(6, 0); push(8, 0); push(9, 1);
    hs0 = hs_cnt;
    load_frame(4'd1, 1'b0);
    collect(4, -1, 0);
    check_frame_end(hs0, 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride2();
    test_sign_modes();
    test_stride0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_conv2d_stream.md
# matrix_conv2d_stream

Parametrised streaming 2-D valid-mode convolution engine, and the next generation of our fixed-size matrix convolver. It loads an M×M image and an F×F kernel over a valid/ready input port, then computes every stride-S window with one MAC per cycle. Each window result is emitted on a valid/ready output port with a last-window marker. It adds three things the previous engine lacks: runtime signed/unsigned arithmetic, backpressure, and a full-precision accumulator.

## Interface
- M, 4: image dimension (M×M elements); 2 ≤ M ≤ 15
- F, 2: kernel dimension (F×F elements); 1 ≤ F ≤ M
- DW, 8: element width in bits
- ACCW, 2*DW+$clog2(F*F): accumulator/output width (derived, do not override)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  load beat valid
- in_ready  out  1  load beat accepted when in_valid&&in_ready
- a  in  DW  image element, row-major
- b  in  DW  kernel element, row-major; sampled on beats 0..F*F-1 only
- stride  in  4  window step S; sampled on load beat 0
- signed_mode  in  1  1 = two's-complement operands; sampled on load beat 0
- out_valid  out  1  window result valid
- out_ready  in  1  downstream accepts result
- out  out  ACCW  window sum (sign-extended when signed_mode)
- out_last  out  1  high with the final window of the frame
- busy  out  1  frame in progress (state≠LOAD or load index≠0)
- err  out  1  one-cycle pulse: stride==0 sampled on beat 0

## Operation
- States: LOAD (reset state), MAC, EMIT.
- LOAD: in_ready=1. Each accepted beat k writes x[k]=a and, if k<F*F, h[k]=b. Beat 0 latches stride and signed_mode.
- After beat M*M-1 is accepted: index returns to 0 and the block goes to MAC with window origin (0,0).
- Stride 0: latched as 1, err pulses on the cycle after beat 0.
- O = floor((M-F)/S)+1 windows per axis, O*O outputs per frame.
- Window order is raster: origin row r*S, col c*S; c is the inner loop, r and c each run 0..O-1. Stride > M-F gives exactly one window.
- MAC: F*F cycles per window, one product per cycle. Products are DW×DW, signed or unsigned per the latched mode. The accumulator is cleared on the first product and cannot overflow.
- MAC → EMIT after the F*F-th product.
- EMIT: out_valid=1, and out/out_last are held stable until out_ready.
- On the handshake: if last window, go to LOAD; otherwise advance to the next origin and go to MAC.
- in_ready=0 in MAC/EMIT; in_valid is ignored there.
- Kernel/image memories are overwritten by the next frame only. No reuse-kernel mode.

## Timing
- Reset (asynchronous assert): state=LOAD, index=0, in_ready=1, out_valid=0, out=0, out_last=0, busy=0, err=0. Any partial load or computation is discarded. Outputs take their reset values immediately on assert.
- Reset deassert: in_ready is high from the first clk edge after deassert.
- Last load beat accepted at edge t: MAC occupies cycles t+1..t+F*F, and out_valid rises after edge t+F*F (visible in cycle t+F*F+1).
- out_ready held high: one result every F*F+1 cycles. out_valid drops for F*F cycles between results.
- out_ready low: zero-throughput stall, no result lost or duplicated.
- After the last handshake: in_ready=1 in the next cycle, and busy=0.
- busy rises the cycle after beat 0 is accepted.

## Test plan
- M=3,F=2,S=1, unsigned, x=1..9, h=1,2,3,4, out_ready=1 → outputs 37,47,67,77; out_last only on 77; first out_valid 5 cycles after last load beat.
- Same data, S=2 → single output 37 with out_last=1, then in_ready=1.
- M=3,F=2,S=1, all x=0xFF, all h=0x80: signed_mode=1 → each out=512; signed_mode=0 → each out=130560 (ACCW=18, no truncation).
- S=0 with the first-case data → err pulses once; outputs identical to S=1 (37,47,67,77).
- out_ready low for 5 cycles on the second result → out=47 and out_last=0 held stable; exactly 4 handshakes per frame; no in_ready during the stall.
- Assert rst mid-MAC of the second window, then load a new frame x=1..9, h=0,0,0,1 → outputs 5,6,8,9 with no stale values; the bench checks reset values immediately on assert.
